// File: rtl/inst_fetcher.sv
// Instruction fetch stage: owns the fetch PC, issues one request at a time on
// the instruction memory bus and buffers returned words in a small FIFO that
// feeds decode. A redirect from execute flushes the buffer, marks any
// in-flight response as stale and restarts fetch at the redirect target.
//
// Optional build macro INST_MISALIGN_CHECK_EN: when defined, a redirect to a
// non word-aligned target issues no fetch; instead a single marker entry with
// if_misaligned=1 is queued and issuing stalls until the next redirect or
// reset. When undefined, redirect targets are forced to word alignment.
module inst_fetcher #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              FIFO_DEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            i_membus_valid,
    input  logic            i_membus_ready,
    output logic [XLEN-1:0] i_membus_addr,
    input  logic            i_membus_rvalid,
    input  logic [31:0]     i_membus_rdata,
    input  logic            control_hazard,
    input  logic [XLEN-1:0] control_hazard_pc_next,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_addr,
    output logic [31:0]     if_bits
`ifdef INST_MISALIGN_CHECK_EN
    ,
    output logic            if_misaligned
`endif
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Fetch control state
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  req_pc;       // address of the request currently in flight
    logic             outstanding;
    logic             discard;      // in-flight response belongs to a flushed path

    // Instruction buffer
    logic [XLEN-1:0]  fifo_addr [FIFO_DEPTH];
    logic [31:0]      fifo_bits [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Per-cycle decisions
    logic             resp_any;
    logic             push;
    logic             pop;
    logic             res_bit;
    logic [CNT_W-1:0] reserved;
    logic             slot_free;
    logic             req_ok;
    logic             handshake;
    logic             head_present;
    logic [XLEN-1:0]  redirect_pc;

`ifdef INST_MISALIGN_CHECK_EN
    logic             fifo_mis [FIFO_DEPTH];
    logic             tgt_misaligned;
    logic             stall;        // parked on a misaligned target

    assign tgt_misaligned = |control_hazard_pc_next[1:0];
    assign redirect_pc    = control_hazard_pc_next;
`else
    logic             unused_tgt_lsb;

    // Targets are always word aligned in this build; the low bits are dropped.
    assign redirect_pc    = {control_hazard_pc_next[XLEN-1:2], 2'b00};
    assign unused_tgt_lsb = ^control_hazard_pc_next[1:0];
`endif

    // Issue gating, response handling and decode handshake for this cycle
    always_comb begin
        resp_any     = i_membus_rvalid && outstanding;
        // A response is kept only if it is not stale and not flushed by a
        // redirect arriving in the very same cycle.
        push         = resp_any && !discard && !control_hazard;
        // A returning stale response frees its reservation outright; a kept
        // response converts its reservation into a buffered entry.
        res_bit      = outstanding && !(resp_any && discard);
        reserved     = count + CNT_W'(res_bit);
        slot_free    = (!outstanding || resp_any) && (reserved < DEPTH_C);
        req_ok       = slot_free && !control_hazard && !rst;
`ifdef INST_MISALIGN_CHECK_EN
        req_ok       = req_ok && !stall;
`endif
        handshake    = req_ok && i_membus_ready;
        head_present = (count != '0);
        if_valid     = head_present && !control_hazard && !rst;
        pop          = if_valid && if_ready;
    end

    // Head entry drives decode directly; an empty buffer presents zeros
    always_comb begin
        if_addr = '0;
        if_bits = '0;
        if (head_present) begin
            if_addr = fifo_addr[rd_ptr];
            if_bits = fifo_bits[rd_ptr];
        end
`ifdef INST_MISALIGN_CHECK_EN
        if_misaligned = head_present && fifo_mis[rd_ptr];
`endif
    end

    assign i_membus_valid = req_ok;
    assign i_membus_addr  = fetch_pc;

    // Control state: PC, outstanding/discard tracking, FIFO pointers and count
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_VECTOR;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
`ifdef INST_MISALIGN_CHECK_EN
            stall       <= 1'b0;
`endif
        end else if (control_hazard) begin
            fetch_pc    <= redirect_pc;
            // A response landing in the redirect cycle is simply dropped; only a
            // still-pending one has to be remembered as stale.
            outstanding <= outstanding && !i_membus_rvalid;
            discard     <= outstanding && !i_membus_rvalid;
            rd_ptr      <= '0;
`ifdef INST_MISALIGN_CHECK_EN
            wr_ptr      <= tgt_misaligned ? PTR_W'(1) : '0;
            count       <= tgt_misaligned ? CNT_W'(1) : '0;
            stall       <= tgt_misaligned;
`else
            wr_ptr      <= '0;
            count       <= '0;
`endif
        end else begin
            if (handshake) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (resp_any) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
            // A new request accepted alongside a response becomes the in-flight one.
            if (handshake) begin
                outstanding <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Data path: request address capture and buffer writes (no reset needed)
    always_ff @(posedge clk) begin
        if (handshake) begin
            req_pc <= fetch_pc;
        end
`ifdef INST_MISALIGN_CHECK_EN
        if (control_hazard && tgt_misaligned) begin
            fifo_addr[0] <= control_hazard_pc_next;
            fifo_bits[0] <= '0;
            fifo_mis[0]  <= 1'b1;
        end else if (push) begin
            fifo_addr[wr_ptr] <= req_pc;
            fifo_bits[wr_ptr] <= i_membus_rdata;
            fifo_mis[wr_ptr]  <= 1'b0;
        end
`else
        if (push) begin
            fifo_addr[wr_ptr] <= req_pc;
            fifo_bits[wr_ptr] <= i_membus_rdata;
        end
`endif
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: a cycle table for the directed scenarios, a short
// reset sequence, then randomized traffic checked against a stream model
// (decode must see consecutive words from the last redirect target, requests
// must follow the same sequence, at most one request in flight).
module tb_inst_fetcher;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_membus_valid;
    logic        i_membus_ready;
    logic [31:0] i_membus_addr;
    logic        i_membus_rvalid;
    logic [31:0] i_membus_rdata;
    logic        control_hazard;
    logic [31:0] control_hazard_pc_next;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_addr;
    logic [31:0] if_bits;
`ifdef INST_MISALIGN_CHECK_EN
    logic        if_misaligned;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetcher #(
        .XLEN(32),
        .RESET_VECTOR(RV),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_membus_valid(i_membus_valid),
        .i_membus_ready(i_membus_ready),
        .i_membus_addr(i_membus_addr),
        .i_membus_rvalid(i_membus_rvalid),
        .i_membus_rdata(i_membus_rdata),
        .control_hazard(control_hazard),
        .control_hazard_pc_next(control_hazard_pc_next),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_addr(if_addr),
        .if_bits(if_bits)
`ifdef INST_MISALIGN_CHECK_EN
        ,
        .if_misaligned(if_misaligned)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    typedef struct {
        bit          r;
        bit          rdy;
        bit          rv;
        logic [31:0] rd;
        bit          ir;
        bit          hz;
        logic [31:0] tg;
        bit          mv;
        logic [31:0] ma;
        bit          iv;
        logic [31:0] ia;
        logic [31:0] ib;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit rdy, input bit rv, input logic [31:0] rd,
                       input bit ir, input bit hz, input logic [31:0] tg,
                       input bit mv, input logic [31:0] ma,
                       input bit iv, input logic [31:0] ia, input logic [31:0] ib);
        vec_t v;
        v.r = r; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir; v.hz = hz; v.tg = tg;
        v.mv = mv; v.ma = ma; v.iv = iv; v.ia = ia; v.ib = ib;
        tbl.push_back(v);
    endtask

    logic        pend;
    logic [31:0] pend_addr;
    int          pend_lat;
    logic [31:0] exp_req;
    logic [31:0] exp_dec;
    logic        rv_now;
    logic [31:0] tgt;
    int          pops;

    initial begin
        rst = 1'b1; i_membus_ready = 1'b0; i_membus_rvalid = 1'b0; i_membus_rdata = '0;
        control_hazard = 1'b0; control_hazard_pc_next = '0; if_ready = 1'b0;

        //   rst rdy rv rdata        ir hz target        mv addr          iv if_addr       if_bits
        // reset then sequential fetch from 0 with a 1-cycle memory
        add(1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        add(0, 1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
        add(0, 1, 1, 32'h13,       1, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0);
        add(0, 1, 1, 32'h13,       1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h13);
        add(0, 1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h8,        1, 32'h4,        32'h13);
        add(0, 1, 1, 32'h13,       1, 0, 32'h0,        1, 32'hC,        0, 32'h0,        32'h0);
        add(0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h13);
        // decode stalled: two requests fill the buffer, then issue stops
        add(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        add(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
        add(0, 1, 1, 32'hA0,       0, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0);
        add(0, 1, 1, 32'hA4,       0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'hA0);
        add(0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'hA0);
        add(0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'hA0);
        add(0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'hA0);
        add(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        1, 32'h4,        32'hA4);
        // redirect to 0x100 while 0x8 is in flight; stale response dropped
        add(0, 1, 0, 32'h0,        1, 1, 32'h100,      0, 32'h0,        0, 32'h0,        32'h0);
        add(0, 1, 1, 32'hDEAD,     1, 0, 32'h0,        1, 32'h100,      0, 32'h0,        32'h0);
        add(0, 1, 1, 32'h11,       1, 0, 32'h0,        1, 32'h104,      0, 32'h0,        32'h0);
        add(0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h100,      32'h11);
        // redirect to 0x200 in the same cycle as a response
        add(0, 1, 1, 32'h22,       1, 1, 32'h200,      0, 32'h0,        0, 32'h0,        32'h0);
        add(0, 1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h200,      0, 32'h0,        32'h0);
        add(0, 1, 1, 32'h33,       1, 0, 32'h0,        1, 32'h204,      0, 32'h0,        32'h0);
        add(0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h200,      32'h33);
        // reset with an entry buffered and 0x204 in flight; late response ignored
        add(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        add(0, 0, 1, 32'h55,       0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
        add(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
        add(0, 1, 1, 32'h66,       0, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h66);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].r; i_membus_ready = tbl[i].rdy; i_membus_rvalid = tbl[i].rv;
            i_membus_rdata = tbl[i].rd; if_ready = tbl[i].ir; control_hazard = tbl[i].hz;
            control_hazard_pc_next = tbl[i].tg;
            #1;
            chk($sformatf("v%0d membus_valid", i), 32'(i_membus_valid), 32'(tbl[i].mv));
            if (tbl[i].mv) chk($sformatf("v%0d membus_addr", i), i_membus_addr, tbl[i].ma);
            chk($sformatf("v%0d if_valid", i), 32'(if_valid), 32'(tbl[i].iv));
            if (tbl[i].iv) begin
                chk($sformatf("v%0d if_addr", i), if_addr, tbl[i].ia);
                chk($sformatf("v%0d if_bits", i), if_bits, tbl[i].ib);
            end
        end

        // Reset over a non-empty buffer: outputs must come back as zeros
        @(negedge clk);
        rst = 1'b1; i_membus_ready = 1'b0; i_membus_rvalid = 1'b0; if_ready = 1'b0;
        control_hazard = 1'b0;
        #1;
        chk("rst_cycle membus_valid", 32'(i_membus_valid), 32'h0);
        chk("rst_cycle if_valid", 32'(if_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst if_valid", 32'(if_valid), 32'h0);
        chk("post_rst if_addr", if_addr, 32'h0);
        chk("post_rst if_bits", if_bits, 32'h0);
        chk("post_rst membus_valid", 32'(i_membus_valid), 32'h1);
        chk("post_rst membus_addr", i_membus_addr, RV);

        // Randomized traffic against the stream model
        pend = 1'b0; pend_addr = '0; pend_lat = 0; exp_req = RV; exp_dec = RV; pops = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rv_now = pend && (pend_lat == 0);
            if (pend && !rv_now) pend_lat--;
            i_membus_rvalid = rv_now;
            i_membus_rdata  = rv_now ? memfn(pend_addr) : $urandom;
            i_membus_ready  = ($urandom_range(0, 3) != 0);
            if_ready        = ($urandom_range(0, 9) < 7);
            control_hazard  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF8 | 32'($urandom_range(0, 3));
            else                           tgt = $urandom & 32'h0000_FFFF;
            control_hazard_pc_next = tgt;
            #1;
            if (rv_now) pend = 1'b0;
            if (control_hazard) begin
                chk("rand redirect if_valid", 32'(if_valid), 32'h0);
                chk("rand redirect membus_valid", 32'(i_membus_valid), 32'h0);
                exp_dec = tgt & ~32'h3;
                exp_req = tgt & ~32'h3;
            end else begin
                if (if_valid && if_ready) begin
                    chk("rand if_addr", if_addr, exp_dec);
                    chk("rand if_bits", if_bits, memfn(exp_dec));
                    exp_dec = exp_dec + 32'h4;
                    pops++;
                end
                if (i_membus_valid && i_membus_ready) begin
                    chk("rand single_outstanding", 32'(pend), 32'h0);
                    chk("rand membus_addr", i_membus_addr, exp_req);
                    exp_req   = exp_req + 32'h4;
                    pend      = 1'b1;
                    pend_addr = i_membus_addr;
                    pend_lat  = $urandom_range(0, 2);
                end
            end
        end
        chk("rand progress", 32'(pops >= 400), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
